// File: rtl/bcd_turn_timer_ctrl_if.sv
// Game-control and BCD-counter signals around the turn timer controller.
// The master side is the game logic plus the counter instance; the slave side is the controller.
interface bcd_turn_timer_ctrl_if;
  logic       Start;
  logic       Stop;
  logic       Pause;
  logic       Shot;
  logic [3:0] Dig1;
  logic [3:0] Dig2;
  logic [3:0] Dig3;
  logic       CounterReset;
  logic       CounterEnable;
  logic       Player;
  logic       Timeout;
  logic [2:0] State;

  modport master (
    output Start, Stop, Pause, Shot, Dig1, Dig2, Dig3,
    input  CounterReset, CounterEnable, Player, Timeout, State
  );

  modport slave (
    input  Start, Stop, Pause, Shot, Dig1, Dig2, Dig3,
    output CounterReset, CounterEnable, Player, Timeout, State
  );
endinterface

// File: rtl/bcd_turn_timer_ctrl.sv
// Per-turn shot timer: drives a 3-digit BCD counter with one-second enables and
// watches its digits for the turn limit, handing the turn over on a shot or a timeout.
//
//   state   | meaning
//   IDLE    | timer stopped, counter held in reset
//   CLEAR   | counter cleared for CLEAR_CYCLES cycles, prescaler zeroed
//   RUN     | prescaler running, one enable per tick, limit compared
//   HOLD    | paused, prescaler frozen
//   EXPIRED | single cycle: Timeout pulse, turn passes to the other player
module bcd_turn_timer_ctrl #(
  parameter int         TICK_DIV     = 27000000,
  parameter int         PRESCALE_W   = 25,
  parameter int         CLEAR_CYCLES = 2,
  parameter logic [3:0] LIMIT_HUN    = 4'd0,
  parameter logic [3:0] LIMIT_TEN    = 4'd3,
  parameter logic [3:0] LIMIT_ONE    = 4'd0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  bcd_turn_timer_ctrl_if.slave  bus
);

  localparam int                    CLR_W     = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIV - 1);
  localparam logic [CLR_W-1:0]      CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [11:0]           LIMIT     = {LIMIT_HUN, LIMIT_TEN, LIMIT_ONE};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    HOLD    = 3'd3,
    EXPIRED = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [CLR_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic                  player_q, player_d;
  logic                  cnt_rst_q, cnt_rst_d;
  logic                  cnt_en_q, cnt_en_d;
  logic                  timeout_q, timeout_d;
  logic                  tick;
  logic                  limit_hit;

  assign tick      = (presc_q == TICK_LAST);
  assign limit_hit = ({bus.Dig3, bus.Dig2, bus.Dig1} == LIMIT);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    clr_cnt_d = clr_cnt_q;
    player_d  = player_q;
    cnt_en_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Start && !bus.Stop) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          presc_d   = '0;
        end
      end

      CLEAR: begin
        if (bus.Stop) begin
          state_d = IDLE;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d = RUN;
          presc_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      RUN: begin
        // The prescaler keeps counting on the exit cycle; a tick lost to an exit is dropped.
        presc_d  = tick ? '0 : presc_q + 1'b1;
        cnt_en_d = tick && !bus.Stop && !bus.Shot && !bus.Pause;
        if (bus.Stop) begin
          state_d = IDLE;
        end else if (bus.Shot) begin
          state_d   = CLEAR;
          player_d  = ~player_q;
          clr_cnt_d = '0;
          presc_d   = '0;
        end else if (limit_hit) begin
          state_d = EXPIRED;
        end else if (bus.Pause) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (bus.Stop) begin
          state_d = IDLE;
        end else if (!bus.Pause) begin
          state_d = RUN;
        end
      end

      EXPIRED: begin
        player_d = ~player_q;
        if (bus.Stop) begin
          state_d = IDLE;
        end else begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          presc_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    cnt_rst_d = (state_d == IDLE) || (state_d == CLEAR);
    timeout_d = (state_d == EXPIRED);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      clr_cnt_q <= '0;
      player_q  <= 1'b0;
      cnt_rst_q <= 1'b1;
      cnt_en_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      clr_cnt_q <= clr_cnt_d;
      player_q  <= player_d;
      cnt_rst_q <= cnt_rst_d;
      cnt_en_q  <= cnt_en_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.State         = state_q;
  assign bus.CounterReset  = cnt_rst_q;
  assign bus.CounterEnable = cnt_en_q;
  assign bus.Player        = player_q;
  assign bus.Timeout       = timeout_q;

endmodule

// File: tb/tb_bcd_turn_timer_ctrl.sv
// Bench for bcd_turn_timer_ctrl: cycle vectors against a behavioural BCD counter,
// then hand-written sequences for Stop in EXPIRED and an asynchronous reset mid-RUN.
module tb_bcd_turn_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_turn_timer_ctrl_if ifc ();

  bcd_turn_timer_ctrl #(
    .TICK_DIV     (4),
    .PRESCALE_W   (2),
    .CLEAR_CYCLES (2),
    .LIMIT_HUN    (4'd0),
    .LIMIT_TEN    (4'd0),
    .LIMIT_ONE    (4'd3)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (ifc)
  );

  // Behavioural 3-digit BCD counter fed by the controller.
  logic [11:0] dig_q;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (r[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (r[7:4] == 4'd9) begin
        r[7:4]  = 4'd0;
        r[11:8] = (r[11:8] == 4'd9) ? 4'd0 : r[11:8] + 4'd1;
      end else begin
        r[7:4] = r[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = r[3:0] + 4'd1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (ifc.CounterReset)       dig_q <= 12'h000;
    else if (ifc.CounterEnable) dig_q <= bcd_inc(dig_q);
  end

  assign ifc.Dig1 = dig_q[3:0];
  assign ifc.Dig2 = dig_q[7:4];
  assign ifc.Dig3 = dig_q[11:8];

  typedef struct {
    logic [3:0]  in;    // {Start, Stop, Pause, Shot}
    logic [2:0]  st;
    logic [3:0]  out;   // {CounterReset, CounterEnable, Player, Timeout}
    logic [11:0] dig;
  } vec_t;

  vec_t vecs[$];

  task automatic addn(input int n, input logic [3:0] in, input logic [2:0] st,
                      input logic [3:0] out, input logic [11:0] dig);
    vec_t v;
    v.in = in; v.st = st; v.out = out; v.dig = dig;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [2:0] st, input logic [3:0] o);
    chk({nm, " State"},         32'(ifc.State),         32'(st));
    chk({nm, " CounterReset"},  32'(ifc.CounterReset),  32'(o[3]));
    chk({nm, " CounterEnable"}, 32'(ifc.CounterEnable), 32'(o[2]));
    chk({nm, " Player"},        32'(ifc.Player),        32'(o[1]));
    chk({nm, " Timeout"},       32'(ifc.Timeout),       32'(o[0]));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;

    rst_n     = 1'b0;
    ifc.Start = 1'b0;
    ifc.Stop  = 1'b0;
    ifc.Pause = 1'b0;
    ifc.Shot  = 1'b0;

    // Start at row 3, three enables, EXPIRED at row 20, Pause rows 25-34,
    // Shot on the cycle digits reach 003 (row 46), Shot/Stop while in HOLD.
    addn(3, 4'b0000, 3'd0, 4'b1000, 12'h000);
    addn(1, 4'b1000, 3'd0, 4'b1000, 12'h000);
    addn(2, 4'b0000, 3'd1, 4'b1000, 12'h000);
    addn(4, 4'b0000, 3'd2, 4'b0000, 12'h000);
    addn(1, 4'b0000, 3'd2, 4'b0100, 12'h000);
    addn(3, 4'b0000, 3'd2, 4'b0000, 12'h001);
    addn(1, 4'b0000, 3'd2, 4'b0100, 12'h001);
    addn(3, 4'b0000, 3'd2, 4'b0000, 12'h002);
    addn(1, 4'b0000, 3'd2, 4'b0100, 12'h002);
    addn(1, 4'b0000, 3'd2, 4'b0000, 12'h003);
    addn(1, 4'b0000, 3'd4, 4'b0001, 12'h003);
    addn(1, 4'b0000, 3'd1, 4'b1010, 12'h003);
    addn(1, 4'b0000, 3'd1, 4'b1010, 12'h000);
    addn(2, 4'b0000, 3'd2, 4'b0010, 12'h000);
    addn(1, 4'b0010, 3'd2, 4'b0010, 12'h000);
    addn(9, 4'b0010, 3'd3, 4'b0010, 12'h000);
    addn(1, 4'b0000, 3'd3, 4'b0010, 12'h000);
    addn(1, 4'b0000, 3'd2, 4'b0010, 12'h000);
    addn(1, 4'b0000, 3'd2, 4'b0110, 12'h000);
    addn(3, 4'b0000, 3'd2, 4'b0010, 12'h001);
    addn(1, 4'b0000, 3'd2, 4'b0110, 12'h001);
    addn(3, 4'b0000, 3'd2, 4'b0010, 12'h002);
    addn(1, 4'b0000, 3'd2, 4'b0110, 12'h002);
    addn(1, 4'b0001, 3'd2, 4'b0010, 12'h003);
    addn(1, 4'b0000, 3'd1, 4'b1000, 12'h003);
    addn(1, 4'b0000, 3'd1, 4'b1000, 12'h000);
    addn(1, 4'b0000, 3'd2, 4'b0000, 12'h000);
    addn(1, 4'b0010, 3'd2, 4'b0000, 12'h000);
    addn(1, 4'b0011, 3'd3, 4'b0000, 12'h000);
    addn(1, 4'b0110, 3'd3, 4'b0000, 12'h000);
    addn(2, 4'b0000, 3'd0, 4'b1000, 12'h000);

    @(negedge clk);
    chk_outs("in reset", 3'd0, 4'b1000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      {ifc.Start, ifc.Stop, ifc.Pause, ifc.Shot} = vecs[i].in;
      @(negedge clk);
      chk_outs($sformatf("row%0d", i), vecs[i].st, vecs[i].out);
      chk($sformatf("row%0d digits", i), 32'(dig_q), 32'(vecs[i].dig));
    end

    // Stop during the EXPIRED cycle: Timeout still pulses, Player still toggles.
    @(posedge clk); #1 ifc.Start = 1'b1;
    @(posedge clk); #1 ifc.Start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (ifc.Timeout) found = 1'b1;
    end
    chk("timeout seen", 32'(found), 32'd1);
    if (found) begin
      chk("expired state", 32'(ifc.State), 32'd4);
      ifc.Stop = 1'b1;
      @(posedge clk); #1 ifc.Stop = 1'b0;
      @(negedge clk);
      chk_outs("stop in expired", 3'd0, 4'b1010);
    end

    // Asynchronous reset between edges while running as player 1.
    @(posedge clk); #1 ifc.Start = 1'b1;
    @(posedge clk); #1 ifc.Start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (ifc.State == 3'd2) found = 1'b1;
    end
    chk("run reached", 32'(found), 32'd1);
    chk("player before reset", 32'(ifc.Player), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outs("async reset", 3'd0, 4'b1000);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_outs("after reset", 3'd0, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
